// File: rtl/uart_pkg.sv
// uart_pkg -- shared definitions for the UART transmit path.
// Holds the frame FSM state encoding, the parity mode encodings, the
// elaboration-time baud divisor calculation and the parity helper.
package uart_pkg;

    // Frame FSM states; a 3-bit encoding keeps the register narrow.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Parity mode encodings used by the PARITY parameter.
    localparam int PAR_NONE = 32'sd0;
    localparam int PAR_EVEN = 32'sd1;
    localparam int PAR_ODD  = 32'sd2;

    // Clock cycles per bit, rounded to the nearest integer.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + (baud / 32'sd2)) / baud;
    endfunction

    // Parity over a zero-extended data word; zero padding does not
    // change the XOR reduction, so one width serves every DATA_BITS.
    function automatic logic calc_parity(input logic [8:0] data, input logic odd);
        return odd ? ~^data : ^data;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// uart_tx_param_if -- valid/ready word handshake into the transmitter.
//   tx_data  : word to send (DATA_BITS wide)
//   tx_valid : tx_data is valid
//   tx_ready : transmitter FIFO can take a word
// master drives data/valid, slave (the transmitter) drives ready.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo -- synchronous FIFO with first-word fall-through read.
//   clk, rst_n : clock and synchronous active-low reset
//   wr_en      : write request; ignored while full (even if a read happens)
//   wr_data    : word to store
//   rd_en      : read request; ignored while empty
//   rd_data    : word at the head of the FIFO (valid while !empty)
//   full/empty : occupancy flags
//   level      : current occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap by overflow.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   rd_en,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   LVL_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   LVL_ZERO = (PTR_W + 1)'(0);
    localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic             push_s;
    logic             pop_s;

    assign full    = (level_q == LVL_FULL);
    assign empty   = (level_q == LVL_ZERO);
    assign level   = level_q;
    assign rd_data = mem_q[rd_ptr_q];

    // A full FIFO refuses writes outright, so a same-edge read cannot make room.
    assign push_s = wr_en && !full;
    assign pop_s  = rd_en && !empty;

    // Next-state for pointers and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   level_d = level_q + LVL_ONE;
            2'b01:   level_d = level_q - LVL_ONE;
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= LVL_ZERO;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_param.sv
// uart_tx_param -- parametrised UART transmitter with a transmit FIFO.
//   clk_Tx     : the only clock, rising edge
//   rst_n      : synchronous active-low reset; aborts any frame and empties the FIFO
//   tx_if      : valid/ready word input (tx_data, tx_valid, tx_ready = !full)
//   tx_out     : registered serial line, idle high
//   tx_busy    : high while a frame is in progress
//   tx_done    : one-cycle pulse in the last cycle of the final stop bit
//   fifo_level : FIFO occupancy
// Bit timing comes from a baud clock-enable counter of DIV cycles per bit.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk_Tx,
    input  logic                        rst_n,
    uart_tx_param_if.slave              tx_if,
    output logic                        tx_out,
    output logic                        tx_busy,
    output logic                        tx_done,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int DIV   = calc_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV >= 2) ? $clog2(DIV) : 1;

    // Reject illegal configurations at elaboration.
    if ((DIV < 2) || (DATA_BITS < 5) || (DATA_BITS > 9) ||
        (PARITY < PAR_NONE) || (PARITY > PAR_ODD) ||
        (STOP_BITS < 1) || (STOP_BITS > 2) || (FIFO_DEPTH < 2) ||
        ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_params
        $error("uart_tx_param: illegal parameter combination");
    end

    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_START  = ST_START;
    localparam logic [2:0] S_DATA   = ST_DATA;
    localparam logic [2:0] S_PARITY = ST_PARITY;
    localparam logic [2:0] S_STOP   = ST_STOP;

    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] DIV_PRE   = CNT_W'(DIV - 2);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [3:0]       DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0]       STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic             PAR_IS_ODD = (PARITY == PAR_ODD);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     baud_cnt_q, baud_cnt_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_out_q, tx_out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 bit_end_s;
    logic                 pop_s;
    logic                 empty_s;
    logic                 full_s;
    logic [DATA_BITS-1:0] head_s;

    uart_tx_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk_Tx),
        .rst_n   (rst_n),
        .wr_en   (tx_if.tx_valid),
        .wr_data (tx_if.tx_data),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .full    (full_s),
        .empty   (empty_s),
        .level   (fifo_level)
    );

    assign tx_if.tx_ready = !full_s;
    assign tx_out         = tx_out_q;
    assign tx_busy        = busy_q;
    assign tx_done        = done_q;

    assign bit_end_s = (baud_cnt_q == DIV_LAST);

    // Frame sequencer: counters, shift register and next line level.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tx_out_d   = tx_out_q;
        done_d     = 1'b0;
        pop_s      = 1'b0;

        if (state_q != S_IDLE) begin
            baud_cnt_d = bit_end_s ? '0 : (baud_cnt_q + CNT_ONE);
        end else begin
            baud_cnt_d = '0;
        end

        case (state_q)
            S_IDLE: begin
                if (!empty_s) begin
                    // Pop and drive the start bit on the same edge.
                    pop_s      = 1'b1;
                    state_d    = S_START;
                    baud_cnt_d = '0;
                    bit_cnt_d  = 4'd0;
                    shift_d    = head_s;
                    par_d      = calc_parity(9'(head_s), PAR_IS_ODD);
                    tx_out_d   = 1'b0;
                end else begin
                    tx_out_d = 1'b1;
                end
            end
            S_START: begin
                if (bit_end_s) begin
                    state_d   = S_DATA;
                    bit_cnt_d = 4'd0;
                    tx_out_d  = shift_q[0];
                end else begin
                    tx_out_d = 1'b0;
                end
            end
            S_DATA: begin
                if (bit_end_s) begin
                    if (bit_cnt_q == DATA_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            state_d  = S_PARITY;
                            tx_out_d = par_q;
                        end else begin
                            state_d   = S_STOP;
                            bit_cnt_d = 4'd0;
                            tx_out_d  = 1'b1;
                        end
                    end else begin
                        // LSB first: the next bit is shift_q[1] before shifting.
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        shift_d   = shift_q >> 1;
                        tx_out_d  = shift_q[1];
                    end
                end else begin
                    tx_out_d = tx_out_q;
                end
            end
            S_PARITY: begin
                if (bit_end_s) begin
                    state_d   = S_STOP;
                    bit_cnt_d = 4'd0;
                    tx_out_d  = 1'b1;
                end else begin
                    tx_out_d = par_q;
                end
            end
            S_STOP: begin
                // Register one cycle early so the pulse lands in the last stop cycle.
                done_d = (bit_cnt_q == STOP_LAST) && (baud_cnt_q == DIV_PRE);
                if (bit_end_s) begin
                    if (bit_cnt_q == STOP_LAST) begin
                        if (!empty_s) begin
                            // Back-to-back frame: no idle cycle in between.
                            pop_s      = 1'b1;
                            state_d    = S_START;
                            baud_cnt_d = '0;
                            bit_cnt_d  = 4'd0;
                            shift_d    = head_s;
                            par_d      = calc_parity(9'(head_s), PAR_IS_ODD);
                            tx_out_d   = 1'b0;
                        end else begin
                            state_d  = S_IDLE;
                            tx_out_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        tx_out_d  = 1'b1;
                    end
                end else begin
                    tx_out_d = 1'b1;
                end
            end
            default: begin
                state_d    = S_IDLE;
                baud_cnt_d = '0;
                bit_cnt_d  = 4'd0;
                tx_out_d   = 1'b1;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Sequencer registers; reset forces the line high directly, no low glitch.
    always_ff @(posedge clk_Tx) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= 4'd0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_out_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_out_q   <= tx_out_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line rate in bit/s.
REQ-003 Parameter DATA_BITS, default 8, data bits per frame; legal range 5..9.
REQ-004 Parameter PARITY, default 0, parity mode: 0 = none, 1 = even, 2 = odd.
REQ-005 Parameter STOP_BITS, default 1, stop bits per frame; legal values 1 or 2.
REQ-006 Parameter FIFO_DEPTH, default 16, transmit FIFO entries; must be a power of two and at least 2.
REQ-007 Port clk_Tx, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-008 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-009 Port tx_data, input, DATA_BITS: word to transmit.
REQ-010 Port tx_valid, input, 1 bit: tx_data is valid.
REQ-011 Port tx_ready, output, 1 bit: FIFO can accept a word; SHALL equal !full.
REQ-012 Port tx_out, output, 1 bit: registered serial line; idle level is high.
REQ-013 Port tx_busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 Port tx_done, output, 1 bit: one-cycle pulse at frame end.
REQ-015 Port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.

Function
REQ-016 DIV SHALL be computed at elaboration as (CLK_HZ + BAUD/2) / BAUD. Elaboration SHALL fail if DIV < 2 or if any parameter is outside its legal range.
REQ-017 Every bit on tx_out SHALL last exactly DIV clk_Tx cycles. Timing SHALL come from a clock-enable counter; no generated or derived clock is permitted.
REQ-018 A word SHALL be pushed into the FIFO on any edge where tx_valid && tx_ready.
- When the FIFO is full, tx_valid SHALL be ignored, even if a pop occurs on the same edge.
- No word SHALL be lost or duplicated.
REQ-019 A simultaneous push and pop on a non-full FIFO SHALL leave fifo_level unchanged. FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 FSM states SHALL be IDLE, START, DATA, PARITY and STOP.
- IDLE -> START: on the first edge with the FIFO non-empty. The word is popped and tx_out is driven to 0 on that same edge.
- START -> DATA: after DIV cycles.
- DATA -> PARITY, or directly to STOP when PARITY = 0: after DATA_BITS bit periods.
- PARITY -> STOP: after DIV cycles.
- STOP -> IDLE or START: after STOP_BITS bit periods.
REQ-021 With the FSM idle and the FIFO empty, tx_out SHALL fall exactly 1 cycle after the handshake edge.
REQ-022 Data bits SHALL be sent LSB first.
REQ-023 The parity bit SHALL be ^data for even parity and ~^data for odd parity.
REQ-024 Frame length SHALL be 1 + DATA_BITS + (PARITY != 0) + STOP_BITS bit periods. tx_out SHALL be 1 during STOP and IDLE.
REQ-025 If the FIFO is non-empty at the end of STOP, the FSM SHALL go directly to START with zero idle cycles between frames.
REQ-026 tx_done SHALL pulse high for exactly one cycle: the last cycle of the final stop bit.
REQ-027 The bit counter and baud counter SHALL restart at 0 on entry to START, so bit timing does not depend on the previous frame.

Reset
REQ-028 While rst_n = 0 at a rising edge, the block SHALL drive the following reset values on the next cycle: tx_out = 1, tx_busy = 0, tx_done = 0, tx_ready = 1, fifo_level = 0.
REQ-029 In the same reset, FIFO pointers, counters and the FSM SHALL clear to IDLE.
REQ-030 Reset mid-frame SHALL abort the frame and discard all FIFO contents. tx_out SHALL return high without glitching low.

Structure
REQ-031 Package uart_pkg SHALL hold:
- the state enum;
- the parity encodings PAR_NONE, PAR_EVEN and PAR_ODD;
- a function computing DIV.
REQ-032 The FIFO SHALL be the sub-module uart_tx_fifo, parametrised by WIDTH and DEPTH, reusable by a future receiver.

Verification (CLK_HZ = 1600000, BAUD = 100000, DIV = 16 unless stated)
REQ-033 8N1, push 0xA5 at edge 0:
- tx_out = 0 over cycles 1-16;
- then bits 1,0,1,0,0,1,0,1 at 16 cycles each;
- stop bit high;
- tx_done at cycle 160.
REQ-034 PARITY = 1, push 0x07: parity bit = 1. With PARITY = 2: parity bit = 0. Frame = 176 cycles.
REQ-035 FIFO_DEPTH = 16:
- Push 20 words back-to-back: tx_ready drops when fifo_level = 16.
- All 20 frames appear in order.
- The next start bit follows each stop bit with no gap.
REQ-036 Assert rst_n = 0 during data bit 3: on the next cycle, tx_out = 1, tx_busy = 0, fifo_level = 0, tx_ready = 1. No further frame bits appear.
REQ-037 DATA_BITS = 7, STOP_BITS = 2, push 0x55: frame = 10 bits = 160 cycles, with 2 high stop periods.
REQ-038 Hold tx_valid high with tx_ready low for 100 cycles: exactly one word is accepted when tx_ready rises, and the FIFO count stays consistent.
